state_machine: RTL and testbench

STATE_MACHINE -- requirements
Module: state_machine

---
 rtl/state_machine_pkg.sv | 34 +++
 rtl/state_machine_if.sv | 57 +++++
 rtl/state_machine.sv | 189 ++++++++++++++++++
 tb/tb_state_machine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/state_machine_pkg.sv
// Shared definitions for the command state machine: command and response codes,
// FSM state encoding and the wait-state timeout limit.
package state_machine_pkg;

  localparam logic [7:0] CMD_RDSR = 8'h52;  // 'R'
  localparam logic [7:0] CMD_RDCR = 8'h45;  // 'E'
  localparam logic [7:0] CMD_WRCR = 8'h47;  // 'G'

  localparam logic [7:0] RSP_ERR     = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // 'T'

  localparam logic [7:0] CSR_WORD_BYTES = 8'd4;

  localparam int unsigned TIMEOUT_LIMIT = 65536;
  localparam int          TIMEOUT_CNT_W = 16;
  localparam logic [TIMEOUT_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CNT_W'(TIMEOUT_LIMIT - 1);

  typedef enum logic [3:0] {
    IDLE,
    DECODE,
    CSR_REQ,
    CSR_WAIT,
    RAM_WR,
    RAM_WR_WAIT,
    RAM_RD,
    RAM_RD_WAIT,
    RESP
  } state_t;

  function automatic logic is_csr_read(input logic [7:0] cmd);
    return (cmd == CMD_RDSR) || (cmd == CMD_RDCR);
  endfunction

endpackage

// File: rtl/state_machine_if.sv
// Command, response, scratch-RAM and CSR-engine signals of the command state machine.
// master: the state machine itself; slave: the surrounding host, RAM sequencers and CSR engine.
interface state_machine_if;

  logic        start_rx;
  logic [7:0]  cmd_rx;
  logic [7:0]  len_rx;

  logic        start_tx;
  logic [7:0]  cmd_tx;
  logic [7:0]  len_tx;

  logic        start_rd_ram;
  logic [7:0]  start_rd_addr;
  logic        done_rd_ram;
  logic [31:0] rd_word;

  logic        start_wr_ram;
  logic [7:0]  start_wr_addr;
  logic [31:0] wr_word;
  logic        done_wr_ram;

  logic        start_rdsr;
  logic        start_rdcr;
  logic        start_wrcr;
  logic [31:0] rd_data_csr;
  logic [31:0] wr_data_csr;
  logic        done_csr;

  logic        done_getimg;
  logic        done_data;

  modport master (
    input  start_rx, cmd_rx, len_rx,
    output start_tx, cmd_tx, len_tx,
    output start_rd_ram, start_rd_addr,
    input  done_rd_ram, rd_word,
    output start_wr_ram, start_wr_addr, wr_word,
    input  done_wr_ram,
    output start_rdsr, start_rdcr, start_wrcr, wr_data_csr,
    input  rd_data_csr, done_csr,
    input  done_getimg, done_data
  );

  modport slave (
    output start_rx, cmd_rx, len_rx,
    input  start_tx, cmd_tx, len_tx,
    input  start_rd_ram, start_rd_addr,
    output done_rd_ram, rd_word,
    input  start_wr_ram, start_wr_addr, wr_word,
    output done_wr_ram,
    input  start_rdsr, start_rdcr, start_wrcr, wr_data_csr,
    output rd_data_csr, done_csr,
    output done_getimg, done_data
  );

endinterface

// File: rtl/state_machine.sv
// Command sequencer: moves CSR words between the CSR engine and scratch RAM word 0.
// Define STATE_MACHINE_TIMEOUT_EN to abort wait states after TIMEOUT_LIMIT idle cycles.
module state_machine
  import state_machine_pkg::*;
#(
  parameter int NUMBER = 256
) (
  input  logic            clk,
  input  logic            reset,
  state_machine_if.master bus
);

  if ((NUMBER < 4) || (NUMBER > 256)) begin : g_number_check
    $error("state_machine: NUMBER must lie in 4..256");
  end

  state_t      state_reg, state_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic [7:0]  len_reg, len_next;
  logic [31:0] csr_data_reg, csr_data_next;
  logic [31:0] wr_data_csr_reg, wr_data_csr_next;
  logic [7:0]  cmd_tx_reg, cmd_tx_next;
  logic [7:0]  len_tx_reg, len_tx_next;

  logic start_tx_c;
  logic start_rd_ram_c;
  logic start_wr_ram_c;
  logic start_rdsr_c;
  logic start_rdcr_c;
  logic start_wrcr_c;

  // Reserved inputs, intentionally unused.
  logic unused_inputs;
  assign unused_inputs = ^{bus.done_getimg, bus.done_data};

`ifdef STATE_MACHINE_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic                     in_wait;

  assign in_wait = (state_reg == CSR_WAIT) || (state_reg == RAM_WR_WAIT) ||
                   (state_reg == RAM_RD_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cmd_reg         <= '0;
      len_reg         <= '0;
      csr_data_reg    <= '0;
      wr_data_csr_reg <= '0;
      cmd_tx_reg      <= '0;
      len_tx_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      cmd_reg         <= cmd_next;
      len_reg         <= len_next;
      csr_data_reg    <= csr_data_next;
      wr_data_csr_reg <= wr_data_csr_next;
      cmd_tx_reg      <= cmd_tx_next;
      len_tx_reg      <= len_tx_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cmd_next         = cmd_reg;
    len_next         = len_reg;
    csr_data_next    = csr_data_reg;
    wr_data_csr_next = wr_data_csr_reg;
    cmd_tx_next      = cmd_tx_reg;
    len_tx_next      = len_tx_reg;
    start_tx_c       = 1'b0;
    start_rd_ram_c   = 1'b0;
    start_wr_ram_c   = 1'b0;
    start_rdsr_c     = 1'b0;
    start_rdcr_c     = 1'b0;
    start_wrcr_c     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start_rx) begin
          cmd_next   = bus.cmd_rx;
          len_next   = bus.len_rx;
          state_next = DECODE;
        end
      end

      DECODE: begin
        if (is_csr_read(cmd_reg)) begin
          state_next = CSR_REQ;
        end else if ((cmd_reg == CMD_WRCR) && (len_reg >= CSR_WORD_BYTES)) begin
          state_next = RAM_RD;
        end else begin
          cmd_tx_next = RSP_ERR;
          len_tx_next = 8'd0;
          state_next  = RESP;
        end
      end

      // Shared by all three commands; WRCR arrives here after its RAM read.
      CSR_REQ: begin
        start_rdsr_c = (cmd_reg == CMD_RDSR);
        start_rdcr_c = (cmd_reg == CMD_RDCR);
        start_wrcr_c = (cmd_reg == CMD_WRCR);
        state_next   = CSR_WAIT;
      end

      CSR_WAIT: begin
        if (bus.done_csr) begin
          if (cmd_reg == CMD_WRCR) begin
            cmd_tx_next = CMD_WRCR;
            len_tx_next = 8'd0;
            state_next  = RESP;
          end else begin
            csr_data_next = bus.rd_data_csr;
            state_next    = RAM_WR;
          end
        end
      end

      RAM_WR: begin
        start_wr_ram_c = 1'b1;
        state_next     = RAM_WR_WAIT;
      end

      RAM_WR_WAIT: begin
        if (bus.done_wr_ram) begin
          cmd_tx_next = cmd_reg;
          len_tx_next = CSR_WORD_BYTES;
          state_next  = RESP;
        end
      end

      RAM_RD: begin
        start_rd_ram_c = 1'b1;
        state_next     = RAM_RD_WAIT;
      end

      RAM_RD_WAIT: begin
        if (bus.done_rd_ram) begin
          wr_data_csr_next = bus.rd_word;
          state_next       = CSR_REQ;
        end
      end

      RESP: begin
        start_tx_c = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

`ifdef STATE_MACHINE_TIMEOUT_EN
    // Counter restarts from zero on every entry into a wait state.
    wait_cnt_next = in_wait ? (wait_cnt_reg + 1'b1) : '0;
    if (in_wait && (state_next == state_reg) && (wait_cnt_reg == TIMEOUT_LAST)) begin
      cmd_tx_next = RSP_TIMEOUT;
      len_tx_next = 8'd0;
      state_next  = RESP;
    end
`endif
  end

  // Outputs are forced low for as long as reset is held, not just after its edge.
  assign bus.start_tx      = start_tx_c & ~reset;
  assign bus.cmd_tx        = reset ? 8'd0 : cmd_tx_reg;
  assign bus.len_tx        = reset ? 8'd0 : len_tx_reg;
  assign bus.start_rd_ram  = start_rd_ram_c & ~reset;
  assign bus.start_rd_addr = 8'd0;
  assign bus.start_wr_ram  = start_wr_ram_c & ~reset;
  assign bus.start_wr_addr = 8'd0;
  assign bus.wr_word       = reset ? 32'd0 : csr_data_reg;
  assign bus.start_rdsr    = start_rdsr_c & ~reset;
  assign bus.start_rdcr    = start_rdcr_c & ~reset;
  assign bus.start_wrcr    = start_wrcr_c & ~reset;
  assign bus.wr_data_csr   = reset ? 32'd0 : wr_data_csr_reg;

endmodule

// File: tb/tb_state_machine.sv
// Directed bench for state_machine: CSR read/write commands, error responses,
// reset behaviour and (with STATE_MACHINE_TIMEOUT_EN) the wait-state timeout.
`timescale 1ns/1ps
module tb_state_machine;

  logic clk = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  int n_tx = 0, n_rd = 0, n_wr = 0, n_rdsr = 0, n_rdcr = 0, n_wrcr = 0, n_multi = 0;

  state_machine_if bus();

  state_machine #(.NUMBER(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  logic [101:0] all_outs;
  assign all_outs = {bus.start_tx, bus.cmd_tx, bus.len_tx, bus.start_rd_ram, bus.start_rd_addr,
                     bus.start_wr_ram, bus.start_wr_addr, bus.wr_word, bus.start_rdsr,
                     bus.start_rdcr, bus.start_wrcr, bus.wr_data_csr};

  // Strobe tally, sampled at the same point the checks use.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.start_tx)     n_tx   <= n_tx + 1;
      if (bus.start_rd_ram) n_rd   <= n_rd + 1;
      if (bus.start_wr_ram) n_wr   <= n_wr + 1;
      if (bus.start_rdsr)   n_rdsr <= n_rdsr + 1;
      if (bus.start_rdcr)   n_rdcr <= n_rdcr + 1;
      if (bus.start_wrcr)   n_wrcr <= n_wrcr + 1;
      if ((int'(bus.start_tx) + int'(bus.start_rd_ram) + int'(bus.start_wr_ram) +
           int'(bus.start_rdsr) + int'(bus.start_rdcr) + int'(bus.start_wrcr)) > 1)
        n_multi <= n_multi + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a command; returns one negedge after the start_rx cycle.
  task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] len);
    bus.cmd_rx   = cmd;
    bus.len_rx   = len;
    bus.start_rx = 1'b1;
    @(negedge clk);
    bus.start_rx = 1'b0;
  endtask

  // 0 tx, 1 rd_ram, 2 wr_ram, 3 rdsr, 4 rdcr, 5 wrcr; checks current cycle first.
  task automatic wait_strobe(input int which, input int max_cycles,
                             output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    forever begin
      case (which)
        0:       seen = bus.start_tx;
        1:       seen = bus.start_rd_ram;
        2:       seen = bus.start_wr_ram;
        3:       seen = bus.start_rdsr;
        4:       seen = bus.start_rdcr;
        5:       seen = bus.start_wrcr;
        default: seen = 1'b0;
      endcase
      if (seen || cycles >= max_cycles) break;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    int base_tx, base_rdsr;
    reset = 1'b1;
    tick(3);
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs);
    end
    // start_rx coincident with reset must be dropped
    bus.cmd_rx   = 8'h52;
    bus.len_rx   = 8'd1;
    bus.start_rx = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.start_rx = 1'b0;
    base_tx   = n_tx;
    base_rdsr = n_rdsr;
    tick(6);
    n_checks++;
    if ((n_tx - base_tx) + (n_rdsr - base_rdsr) !== 0) begin
      n_fail++;
      $display("FAIL reset_drop_rx: got %0d strobes expected 0", (n_tx - base_tx) + (n_rdsr - base_rdsr));
    end
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got %h expected 0", all_outs);
    end
    $display("txn reset: outputs=%h", all_outs);
  endtask

  task automatic test_rdsr;
    int base_other;
    base_other = n_rdcr + n_wrcr + n_rd;
    send_cmd(8'h52, 8'd1);
    n_checks++;
    if (bus.start_rdsr !== 1'b0) begin
      n_fail++;
      $display("FAIL rdsr_early: got %b expected 0", bus.start_rdsr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.start_rdsr !== 1'b1) begin
      n_fail++;
      $display("FAIL rdsr_timing: got %b expected 1", bus.start_rdsr);
    end
    @(negedge clk);
    n_checks++;
    if (bus.start_rdsr !== 1'b0) begin
      n_fail++;
      $display("FAIL rdsr_width: got %b expected 0", bus.start_rdsr);
    end
    tick(2);
    bus.done_csr    = 1'b1;
    bus.rd_data_csr = 32'hA1B2C3D4;
    @(negedge clk);
    bus.done_csr    = 1'b0;
    bus.rd_data_csr = 32'h0;
    n_checks++;
    if ({bus.start_wr_ram, bus.start_wr_addr, bus.wr_word} !== {1'b1, 8'h00, 32'hA1B2C3D4}) begin
      n_fail++;
      $display("FAIL rdsr_wr_ram: got %b/%h/%h expected 1/00/a1b2c3d4",
               bus.start_wr_ram, bus.start_wr_addr, bus.wr_word);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.start_wr_ram, bus.start_tx} !== 2'b00) begin
      n_fail++;
      $display("FAIL rdsr_wait: got wr=%b tx=%b expected 0/0", bus.start_wr_ram, bus.start_tx);
    end
    bus.done_wr_ram = 1'b1;
    @(negedge clk);
    bus.done_wr_ram = 1'b0;
    n_checks++;
    if ({bus.start_tx, bus.cmd_tx, bus.len_tx} !== {1'b1, 8'h52, 8'd4}) begin
      n_fail++;
      $display("FAIL rdsr_resp: got %b/%h/%0d expected 1/52/4", bus.start_tx, bus.cmd_tx, bus.len_tx);
    end
    @(negedge clk);
    n_checks++;
    if ({bus.start_tx, bus.cmd_tx, bus.len_tx} !== {1'b0, 8'h52, 8'd4}) begin
      n_fail++;
      $display("FAIL rdsr_hold: got %b/%h/%0d expected 0/52/4", bus.start_tx, bus.cmd_tx, bus.len_tx);
    end
    tick(2);
    n_checks++;
    if (n_rdcr + n_wrcr + n_rd - base_other !== 0) begin
      n_fail++;
      $display("FAIL rdsr_stray: got %0d other strobes expected 0", n_rdcr + n_wrcr + n_rd - base_other);
    end
    $display("txn rdsr: cmd_tx=%h len_tx=%0d", bus.cmd_tx, bus.len_tx);
  endtask

  task automatic test_rdcr;
    int cyc;
    bit seen;
    send_cmd(8'h45, 8'd0);
    wait_strobe(4, 10, cyc, seen);
    n_checks++;
    if (!seen || cyc !== 1) begin
      n_fail++;
      $display("FAIL rdcr_req: got seen=%b after %0d expected seen after 1", seen, cyc);
    end
    tick(3);
    bus.done_csr    = 1'b1;
    bus.rd_data_csr = 32'h12345678;
    @(negedge clk);
    bus.done_csr    = 1'b0;
    wait_strobe(2, 10, cyc, seen);
    n_checks++;
    if (!seen || bus.wr_word !== 32'h12345678) begin
      n_fail++;
      $display("FAIL rdcr_wr_word: got seen=%b word=%h expected 1/12345678", seen, bus.wr_word);
    end
    tick(1);
    bus.done_wr_ram = 1'b1;
    @(negedge clk);
    bus.done_wr_ram = 1'b0;
    wait_strobe(0, 10, cyc, seen);
    n_checks++;
    if (!seen || {bus.cmd_tx, bus.len_tx} !== {8'h45, 8'd4}) begin
      n_fail++;
      $display("FAIL rdcr_resp: got seen=%b %h/%0d expected 1 45/4", seen, bus.cmd_tx, bus.len_tx);
    end
    tick(2);
    $display("txn rdcr: cmd_tx=%h len_tx=%0d", bus.cmd_tx, bus.len_tx);
  endtask

  task automatic test_wrcr;
    int cyc, base_tx, base_rdsr;
    bit seen;
    base_tx   = n_tx;
    base_rdsr = n_rdsr;
    send_cmd(8'h47, 8'd4);
    wait_strobe(1, 10, cyc, seen);
    n_checks++;
    if (!seen || bus.start_rd_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL wrcr_rd_ram: got seen=%b addr=%h expected 1/00", seen, bus.start_rd_addr);
    end
    tick(1);
    // done pulses for other engines must not advance the wait
    bus.done_csr    = 1'b1;
    bus.done_wr_ram = 1'b1;
    @(negedge clk);
    bus.done_csr    = 1'b0;
    bus.done_wr_ram = 1'b0;
    n_checks++;
    if ({bus.start_wrcr, bus.start_tx} !== 2'b00) begin
      n_fail++;
      $display("FAIL wrcr_stray_done: got wrcr=%b tx=%b expected 0/0", bus.start_wrcr, bus.start_tx);
    end
    bus.rd_word     = 32'hCAFEF00D;
    bus.done_rd_ram = 1'b1;
    @(negedge clk);
    bus.done_rd_ram = 1'b0;
    bus.rd_word     = 32'h0;
    n_checks++;
    if ({bus.start_wrcr, bus.wr_data_csr} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL wrcr_req: got %b/%h expected 1/cafef00d", bus.start_wrcr, bus.wr_data_csr);
    end
    @(negedge clk);
    send_cmd(8'h52, 8'd1);
    bus.done_csr = 1'b1;
    @(negedge clk);
    bus.done_csr = 1'b0;
    wait_strobe(0, 10, cyc, seen);
    n_checks++;
    if (!seen || {bus.cmd_tx, bus.len_tx} !== {8'h47, 8'd0}) begin
      n_fail++;
      $display("FAIL wrcr_resp: got seen=%b %h/%0d expected 1 47/0", seen, bus.cmd_tx, bus.len_tx);
    end
    tick(6);
    n_checks++;
    if ((n_tx - base_tx) !== 1 || (n_rdsr - base_rdsr) !== 0) begin
      n_fail++;
      $display("FAIL busy_rx_ignored: got tx=%0d rdsr=%0d expected 1/0", n_tx - base_tx, n_rdsr - base_rdsr);
    end
    n_checks++;
    if (bus.wr_data_csr !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL wrcr_hold: got %h expected cafef00d", bus.wr_data_csr);
    end
    $display("txn wrcr: wr_data_csr=%h cmd_tx=%h", bus.wr_data_csr, bus.cmd_tx);
  endtask

  task automatic test_errors;
    logic [7:0] cmds [2];
    logic [7:0] lens [2];
    int cyc, base;
    bit seen;
    cmds[0] = 8'h47; lens[0] = 8'd2;
    cmds[1] = 8'h00; lens[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      base = n_rd + n_wr + n_rdsr + n_rdcr + n_wrcr;
      send_cmd(cmds[i], lens[i]);
      wait_strobe(0, 10, cyc, seen);
      n_checks++;
      if (!seen || {bus.cmd_tx, bus.len_tx} !== {8'h3F, 8'd0}) begin
        n_fail++;
        $display("FAIL err_resp[%0d]: got seen=%b %h/%0d expected 1 3f/0", i, seen, bus.cmd_tx, bus.len_tx);
      end
      tick(4);
      n_checks++;
      if (n_rd + n_wr + n_rdsr + n_rdcr + n_wrcr - base !== 0) begin
        n_fail++;
        $display("FAIL err_no_strobe[%0d]: got %0d expected 0", i, n_rd + n_wr + n_rdsr + n_rdcr + n_wrcr - base);
      end
      $display("txn error cmd=%h len=%0d: cmd_tx=%h", cmds[i], lens[i], bus.cmd_tx);
    end
  endtask

  task automatic test_reset_abort;
    int cyc, base_tx, base_wr;
    bit seen;
    send_cmd(8'h52, 8'd1);
    wait_strobe(3, 10, cyc, seen);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (all_outs !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got %h expected 0", all_outs);
    end
    @(negedge clk);
    reset   = 1'b0;
    base_tx = n_tx;
    base_wr = n_wr;
    bus.done_csr    = 1'b1;
    bus.rd_data_csr = 32'hDEADBEEF;
    @(negedge clk);
    bus.done_csr = 1'b0;
    tick(6);
    n_checks++;
    if ((n_tx - base_tx) + (n_wr - base_wr) !== 0) begin
      n_fail++;
      $display("FAIL abort_no_tx: got %0d strobes expected 0", (n_tx - base_tx) + (n_wr - base_wr));
    end
    send_cmd(8'h52, 8'd1);
    wait_strobe(3, 10, cyc, seen);
    tick(1);
    bus.done_csr    = 1'b1;
    bus.rd_data_csr = 32'h55AA0FF0;
    @(negedge clk);
    bus.done_csr = 1'b0;
    wait_strobe(2, 10, cyc, seen);
    tick(1);
    bus.done_wr_ram = 1'b1;
    @(negedge clk);
    bus.done_wr_ram = 1'b0;
    wait_strobe(0, 10, cyc, seen);
    n_checks++;
    if (!seen || {bus.cmd_tx, bus.len_tx, bus.wr_word} !== {8'h52, 8'd4, 32'h55AA0FF0}) begin
      n_fail++;
      $display("FAIL after_reset_rdsr: got seen=%b %h/%0d/%h expected 1 52/4/55aa0ff0",
               seen, bus.cmd_tx, bus.len_tx, bus.wr_word);
    end
    tick(2);
    $display("txn reset_abort then rdsr: cmd_tx=%h wr_word=%h", bus.cmd_tx, bus.wr_word);
  endtask

`ifdef STATE_MACHINE_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    bit seen;
    send_cmd(8'h52, 8'd1);
    wait_strobe(0, 70000, cyc, seen);
    n_checks++;
    if (!seen || {bus.cmd_tx, bus.len_tx} !== {8'h54, 8'd0} || cyc !== 65538) begin
      n_fail++;
      $display("FAIL timeout: got seen=%b %h/%0d after %0d expected 1 54/0 after 65538",
               seen, bus.cmd_tx, bus.len_tx, cyc);
    end
    tick(2);
    $display("txn timeout: cmd_tx=%h cycles=%0d", bus.cmd_tx, cyc);
  endtask
`endif

  task automatic test_one_strobe;
    n_checks++;
    if (n_multi !== 0) begin
      n_fail++;
      $display("FAIL one_strobe: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.start_rx    = 1'b0;
    bus.cmd_rx      = 8'h0;
    bus.len_rx      = 8'h0;
    bus.done_rd_ram = 1'b0;
    bus.rd_word     = 32'h0;
    bus.done_wr_ram = 1'b0;
    bus.rd_data_csr = 32'h0;
    bus.done_csr    = 1'b0;
    bus.done_getimg = 1'b0;
    bus.done_data   = 1'b0;
    @(negedge clk);
    test_reset();
    test_rdsr();
    test_rdcr();
    test_wrcr();
    test_errors();
    test_reset_abort();
`ifdef STATE_MACHINE_TIMEOUT_EN
    test_timeout();
`endif
    test_one_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
